// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: cache client port plus the decode-facing valid/ready head.
// master is the fetch unit; slave is the cache/decode side.
interface fetch_unit_if;
  logic        cache_address_enable;
  logic [31:0] cache_address;
  logic        cache_data_valid;
  logic [31:0] cache_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;

  modport master (
    output cache_address_enable, cache_address, out_valid, out_pc, out_instruction,
    input  cache_data_valid, cache_data, out_ready
  );

  modport slave (
    input  cache_address_enable, cache_address, out_valid, out_pc, out_instruction,
    output cache_data_valid, cache_data, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word-aligned cache reads, buffers {pc, instruction}
// in a small FIFO for decode, and absorbs redirects without disturbing an in-flight miss.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  fetch_unit_if.master bus,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {ST_WAIT, ST_REQ, ST_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     pending_pc_q, pending_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [31:0]     pc_mem_q  [DEPTH];
  logic [31:0]     pc_mem_d  [DEPTH];
  logic [31:0]     ins_mem_q [DEPTH];
  logic [31:0]     ins_mem_d [DEPTH];

  logic [31:0]     redirect_target;
  logic            out_valid_int;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count_after_pop;

  // A redirect cancels both the pop and the push of its own cycle.
  always_comb begin
    redirect_target = redirect_pc & 32'hFFFF_FFFC;
    out_valid_int   = (count_q != '0) && !redirect;
    pop             = out_valid_int && bus.out_ready;
    push            = (state_q == ST_REQ) && bus.cache_data_valid && !redirect;
    count_after_pop = count_q - CW'(pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT: begin
        if (redirect || (count_after_pop < CW'(DEPTH))) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (redirect) begin
          state_d = bus.cache_data_valid ? ST_REQ : ST_DRAIN;
        end else if (bus.cache_data_valid && ((count_after_pop + CW'(1)) == CW'(DEPTH))) begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (bus.cache_data_valid) state_d = ST_REQ;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    bus.cache_address_enable = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  end

  // fetch_pc only moves on data_valid, so the cache sees a stable address through a miss.
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    case (state_q)
      ST_WAIT: begin
        if (redirect) fetch_pc_d = redirect_target;
      end
      ST_REQ: begin
        if (bus.cache_data_valid) begin
          fetch_pc_d = redirect ? redirect_target : fetch_pc_q + 32'd4;
        end else if (redirect) begin
          pending_pc_d = redirect_target;
        end
      end
      ST_DRAIN: begin
        if (bus.cache_data_valid) begin
          fetch_pc_d = redirect ? redirect_target : pending_pc_q;
        end else if (redirect) begin
          pending_pc_d = redirect_target;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_mem_d  = pc_mem_q;
    ins_mem_d = ins_mem_q;
    if (push) begin
      pc_mem_d[tail_q]  = fetch_pc_q;
      ins_mem_d[tail_q] = bus.cache_data;
    end
    if (redirect) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      count_d = count_after_pop + CW'(push);
      head_d  = head_q + PW'(pop);
      tail_d  = tail_q + PW'(push);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= '0;
      count_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      pc_mem_q     <= '{default: '0};
      ins_mem_q    <= '{default: '0};
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      count_q      <= count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      pc_mem_q     <= pc_mem_d;
      ins_mem_q    <= ins_mem_d;
    end
  end

  assign bus.cache_address   = fetch_pc_q;
  assign bus.out_valid       = out_valid_int;
  assign bus.out_pc          = pc_mem_q[head_q];
  assign bus.out_instruction = ins_mem_q[head_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: the bench plays the instruction cache and decode, and compares
// every cycle against a queue-based model of the fetch stage plus hand-computed pins.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam int          M_IDLE   = 0;
  localparam int          M_FETCH  = 1;
  localparam int          M_FLUSH  = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } entry_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus.master),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_pass = 0;
  entry_t      mq[$];
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  logic        cur_rd, cur_rdy, cur_dv;
  logic [31:0] cur_rpc;
  int          miss_left = -1;
  logic [31:0] miss_addr = 32'h1;
  int          miss_lat = 1;
  bit          rand_miss = 1'b0;

  function automatic logic [31:0] cacheWord(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Model comparison for the current cycle; out_valid is cut by a same-cycle redirect.
  task automatic checkOutput();
    logic exp_valid;
    exp_valid = (mq.size() != 0) && !cur_rd;
    checkValue("cache_address_enable", {31'b0, bus.cache_address_enable}, {31'b0, m_mode != M_IDLE});
    checkValue("cache_address", bus.cache_address, m_pc);
    checkValue("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      checkValue("out_pc", bus.out_pc, mq[0].pc);
      checkValue("out_instruction", bus.out_instruction, mq[0].ins);
    end
  endtask

  // Drives one cycle's inputs at posedge+1 and acts as the cache; compares at posedge+5.
  task automatic applyStimulus(input logic rd, input logic [31:0] rpc, input logic rdy);
    int lat;
    cur_rd = rd; cur_rpc = rpc; cur_rdy = rdy; cur_dv = 1'b0;
    redirect = rd; redirect_pc = rpc; bus.out_ready = rdy;
    if (bus.cache_address_enable) begin
      if (miss_left < 0) begin
        lat = 1;
        if (bus.cache_address == miss_addr) begin
          lat = miss_lat;
          miss_addr = 32'h1;
        end else if (rand_miss && $urandom_range(0, 2) == 0) begin
          lat = $urandom_range(2, 4);
        end
        miss_left = lat - 1;
      end
      if (miss_left == 0) begin
        cur_dv = 1'b1;
        miss_left = -1;
      end else begin
        miss_left--;
      end
    end
    bus.cache_data_valid = cur_dv;
    bus.cache_data = cacheWord(bus.cache_address);
    #4;
    checkOutput();
  endtask

  task automatic updateModel();
    int          cnt0;
    logic        pop;
    logic [31:0] tgt;
    entry_t      e;
    cnt0 = mq.size();
    pop  = (cnt0 != 0) && !cur_rd && cur_rdy;
    tgt  = cur_rpc & 32'hFFFF_FFFC;
    if (cur_rd) begin
      mq.delete();
      case (m_mode)
        M_IDLE:  begin m_pc = tgt; m_mode = M_FETCH; end
        M_FETCH: begin
          if (cur_dv) m_pc = tgt;
          else begin m_pend = tgt; m_mode = M_FLUSH; end
        end
        default: begin
          if (cur_dv) begin m_pc = tgt; m_mode = M_FETCH; end
          else m_pend = tgt;
        end
      endcase
    end else begin
      if (pop) void'(mq.pop_front());
      case (m_mode)
        M_IDLE: if (cnt0 - int'(pop) < DEPTH) m_mode = M_FETCH;
        M_FETCH: begin
          if (cur_dv) begin
            e.pc = m_pc; e.ins = cacheWord(m_pc);
            mq.push_back(e);
            m_pc = m_pc + 32'd4;
            if (mq.size() == DEPTH) m_mode = M_IDLE;
          end
        end
        default: if (cur_dv) begin m_pc = m_pend; m_mode = M_FETCH; end
      endcase
    end
  endtask

  task automatic endCycle();
    updateModel();
    @(posedge clock);
    #1;
  endtask

  // Asserts reset mid-cycle (checks the asynchronous values) and releases it at posedge+1.
  task automatic doReset();
    reset_n = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    bus.out_ready = 1'b0; bus.cache_data_valid = 1'b0; bus.cache_data = '0;
    miss_left = -1; miss_addr = 32'h1;
    #2;
    checkValue("reset enable", {31'b0, bus.cache_address_enable}, 32'd0);
    checkValue("reset address", bus.cache_address, RESET_PC);
    checkValue("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkValue("reset out_pc", bus.out_pc, 32'd0);
    checkValue("reset out_instruction", bus.out_instruction, 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    mq.delete();
    m_mode = M_IDLE; m_pc = RESET_PC; m_pend = '0;
  endtask

  initial begin
    bus.out_ready = 1'b0; bus.cache_data_valid = 1'b0; bus.cache_data = '0;
    @(posedge clock);
    #1;

    // Streaming hits with decode always ready.
    doReset();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, '0, 1'b1);
      if (c == 1) begin
        checkValue("s1 c1 enable", {31'b0, bus.cache_address_enable}, 32'd1);
        checkValue("s1 c1 address", bus.cache_address, 32'h0);
      end
      if (c == 2) begin
        checkValue("s1 c2 address", bus.cache_address, 32'h4);
        checkValue("s1 c2 out_pc", bus.out_pc, 32'h0);
        checkValue("s1 c2 out_instruction", bus.out_instruction, 32'hC0DE_0000);
      end
      if (c == 3) begin
        checkValue("s1 c3 address", bus.cache_address, 32'h8);
        checkValue("s1 c3 out_pc", bus.out_pc, 32'h4);
      end
      endCycle();
    end

    // FIFO fills with decode stalled; one pop restarts fetching.
    doReset();
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, '0, c == 3);
      if (c == 3) begin
        checkValue("s2 c3 enable", {31'b0, bus.cache_address_enable}, 32'd0);
        checkValue("s2 c3 out_valid", {31'b0, bus.out_valid}, 32'd1);
        checkValue("s2 c3 out_pc", bus.out_pc, 32'h0);
      end
      if (c == 4) begin
        checkValue("s2 c4 enable", {31'b0, bus.cache_address_enable}, 32'd1);
        checkValue("s2 c4 address", bus.cache_address, 32'h8);
        checkValue("s2 c4 out_pc", bus.out_pc, 32'h4);
      end
      endCycle();
    end

    // 3-cycle miss at 0x10.
    doReset();
    miss_addr = 32'h10; miss_lat = 3;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, '0, 1'b1);
      if (c >= 5 && c <= 7) begin
        checkValue("s3 miss enable", {31'b0, bus.cache_address_enable}, 32'd1);
        checkValue("s3 miss address", bus.cache_address, 32'h10);
      end
      if (c == 6) checkValue("s3 c6 out_valid", {31'b0, bus.out_valid}, 32'd0);
      if (c == 8) begin
        checkValue("s3 c8 address", bus.cache_address, 32'h14);
        checkValue("s3 c8 out_pc", bus.out_pc, 32'h10);
      end
      endCycle();
    end

    // Redirect while the miss at 0x20 is in flight.
    doReset();
    miss_addr = 32'h20; miss_lat = 3;
    for (int c = 0; c < 15; c++) begin
      applyStimulus(c == 9, 32'h100, 1'b1);
      if (c == 9) checkValue("s4 c9 out_valid", {31'b0, bus.out_valid}, 32'd0);
      if (c == 10 || c == 11) checkValue("s4 drain address", bus.cache_address, 32'h20);
      if (c == 11) checkValue("s4 c11 out_valid", {31'b0, bus.out_valid}, 32'd0);
      if (c == 12) checkValue("s4 c12 address", bus.cache_address, 32'h100);
      if (c == 13) checkValue("s4 c13 out_pc", bus.out_pc, 32'h100);
      endCycle();
    end

    // Redirect coinciding with a hit and a ready decode.
    doReset();
    for (int c = 0; c < 6; c++) begin
      applyStimulus(c == 2, 32'h100, 1'b1);
      if (c == 2) checkValue("s5 c2 out_valid", {31'b0, bus.out_valid}, 32'd0);
      if (c == 3) begin
        checkValue("s5 c3 address", bus.cache_address, 32'h100);
        checkValue("s5 c3 out_valid", {31'b0, bus.out_valid}, 32'd0);
      end
      if (c == 4) begin
        checkValue("s5 c4 out_pc", bus.out_pc, 32'h100);
        checkValue("s5 c4 out_instruction", bus.out_instruction, 32'hC0DE_0100);
      end
      endCycle();
    end

    // Unaligned redirect near the top of the address space wraps to 0.
    doReset();
    for (int c = 0; c < 7; c++) begin
      applyStimulus(c == 2, 32'hFFFF_FFFF, 1'b1);
      if (c == 3) checkValue("s6 c3 address", bus.cache_address, 32'hFFFF_FFFC);
      if (c == 4) begin
        checkValue("s6 c4 address", bus.cache_address, 32'h0);
        checkValue("s6 c4 out_pc", bus.out_pc, 32'hFFFF_FFFC);
      end
      if (c == 5) checkValue("s6 c5 out_pc", bus.out_pc, 32'h0);
      endCycle();
    end

    // Random traffic with misses, stalls and redirects, plus one reset mid-run.
    doReset();
    rand_miss = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      logic        rd;
      logic [31:0] rpc;
      if (c == 700) doReset();
      rd  = ($urandom_range(0, 15) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      applyStimulus(rd, rpc, $urandom_range(0, 3) != 0);
      endCycle();
    end

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
